// File: rtl/toggle_hs_pkg.sv
// Shared constants for the toggle-handshake receiver: state encoding,
// synchroniser depth limits and default widths.
package toggle_hs_pkg;

  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

endpackage

// File: rtl/toggle_handshake_rx_sync_chain.sv
// sync_chain: N-flop single-bit synchroniser with async active-high reset.
// Shared by the receiver (req_tgl) and the transmitter (ack_tgl).
module sync_chain #(
  parameter int unsigned N = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] r_chain;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[N-2:0], d};
    end
  end

  assign q = r_chain[N-1];

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receiving end of a two-phase toggle handshake with valid/ready output,
// transfer counter and sticky overrun flag. Define TOGGLE_RX_COUNT_SAT_EN to saturate the counter.
module toggle_handshake_rx
  import toggle_hs_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready,
  output logic              ack_tgl,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic [CNT_W-1:0]  event_count,
  output logic              overrun
);

  // Out-of-range depths are clamped to the legal window.
  localparam int unsigned SYNC_N =
    (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
    (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;

  logic              w_req_sync;
  logic              w_tgl_det;
  logic              w_capture;
  logic              w_accept;
  logic              w_viol;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_req_seen;
  logic              r_ack;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_count;
  logic              r_overrun;

  sync_chain #(.N(SYNC_N)) u_req_sync (
    .clock (clock),
    .reset (reset),
    .d     (req_tgl),
    .q     (w_req_sync)
  );

  assign w_tgl_det = w_req_sync ^ r_req_seen;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    w_viol      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tgl_det) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        // A toggle seen while still full means the sender did not wait for ack.
        w_viol = w_tgl_det;
        if (ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req_seen <= 1'b0;
      r_data     <= '0;
      r_ack      <= 1'b0;
      r_count    <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_data     <= data_in;
        r_req_seen <= w_req_sync;
      end
      if (w_accept) begin
        r_ack <= ~r_ack;
`ifdef TOGGLE_RX_COUNT_SAT_EN
        if (r_count != '1) begin
          r_count <= r_count + CNT_W'(1);
        end
`else
        r_count <= r_count + CNT_W'(1);
`endif
      end
      if (w_viol) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign ack_tgl     = r_ack;
  assign data_out    = r_data;
  assign valid       = (r_state == ST_FULL);
  assign event_count = r_count;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Self-checking bench for toggle_handshake_rx (DATA_W=8, SYNC_STAGES=2, CNT_W=4);
// reference model tracks completed transfers, ack parity and overrun as plain counts.
module tb_toggle_handshake_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_tgl = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       ready = 1'b0;
  logic       ack_tgl;
  logic [7:0] data_out;
  logic       valid;
  logic [3:0] event_count;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_count   = 0;
  bit m_ack     = 1'b0;
  bit m_overrun = 1'b0;

  toggle_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_tgl     (req_tgl),
    .data_in     (data_in),
    .ready       (ready),
    .ack_tgl     (ack_tgl),
    .data_out    (data_out),
    .valid       (valid),
    .event_count (event_count),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] exp_cnt();
`ifdef TOGGLE_RX_COUNT_SAT_EN
    return (m_count > 15) ? 4'hF : 4'(m_count);
`else
    return 4'(m_count % 16);
`endif
  endfunction

  task automatic model_reset();
    m_count   = 0;
    m_ack     = 1'b0;
    m_overrun = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset   = 1'b1;
    req_tgl = 1'b0;
    ready   = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Waits (bounded) for valid; records a failure on timeout.
  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: valid timeout, valid=%b required=1", name, valid);
    end
  endtask

  // One compliant transfer with `hold` cycles of back-pressure, checked against the model.
  task automatic xfer(input logic [7:0] d, input int hold, input string name);
    bit ok;
    ready   = 1'b0;
    data_in = d;
    req_tgl = ~req_tgl;
    wait_valid(name, ok);
    if (ok) begin
      n_tests++;
      if (data_out !== d) begin
        n_fail++;
        $display("FAIL %s data: got %h required %h", name, data_out, d);
      end
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        n_tests++;
        if (valid !== 1'b1 || data_out !== d || ack_tgl !== m_ack) begin
          n_fail++;
          $display("FAIL %s hold%0d: valid=%b data=%h ack=%b required 1 %h %b",
                   name, i, valid, data_out, ack_tgl, d, m_ack);
        end
      end
      ready = 1'b1;
      @(negedge clock);
      ready = 1'b0;
      m_count++;
      m_ack = ~m_ack;
      n_tests++;
      if (ack_tgl !== m_ack || valid !== 1'b0 || event_count !== exp_cnt() ||
          overrun !== m_overrun) begin
        n_fail++;
        $display("FAIL %s accept: ack=%b valid=%b cnt=%h ovr=%b required %b 0 %h %b",
                 name, ack_tgl, valid, event_count, overrun, m_ack, exp_cnt(), m_overrun);
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    #1;
    n_tests++;
    if (ack_tgl !== 1'b0 || data_out !== 8'h00 || valid !== 1'b0 ||
        event_count !== 4'h0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ack=%b data=%h valid=%b cnt=%h ovr=%b required all 0",
               ack_tgl, data_out, valid, event_count, overrun);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    // ready while idle must have no effect
    ready = 1'b1;
    repeat (3) @(negedge clock);
    ready = 1'b0;
    n_tests++;
    if (ack_tgl !== 1'b0 || event_count !== 4'h0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: ack=%b cnt=%h valid=%b required 0 0 0",
               ack_tgl, event_count, valid);
    end
    // Reset asserted mid-FULL clears outputs without a clock edge
    data_in = 8'hA5;
    req_tgl = ~req_tgl;
    wait_valid("reset_midfull", ok);
    #2;
    reset   = 1'b1;
    req_tgl = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (valid !== 1'b0 || data_out !== 8'h00 || ack_tgl !== 1'b0 || event_count !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_async: valid=%b data=%h ack=%b cnt=%h required all 0",
               valid, data_out, ack_tgl, event_count);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    xfer(8'h5A, 0, "after_reset");
  endtask

  task automatic test_single();
    logic [7:0] vhist;
    ready   = 1'b1;
    data_in = 8'h3C;
    req_tgl = ~req_tgl;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vhist[i] = valid;
      if (i == 2) begin
        n_tests++;
        if (data_out !== 8'h3C) begin
          n_fail++;
          $display("FAIL single_data: got %h required 3c", data_out);
        end
      end
    end
    ready = 1'b0;
    m_count++;
    m_ack = ~m_ack;
    n_tests++;
    if (vhist[3:0] !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_latency: valid per cycle=%b required 0100", vhist[3:0]);
    end
    n_tests++;
    if (ack_tgl !== m_ack || event_count !== exp_cnt()) begin
      n_fail++;
      $display("FAIL single_ack: ack=%b cnt=%h required %b %h",
               ack_tgl, event_count, m_ack, exp_cnt());
    end
  endtask

  task automatic test_backpressure();
    xfer(8'hC3, 10, "backpressure");
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_overrun: got %b required 0", overrun);
    end
  endtask

  task automatic test_violation();
    bit ok;
    ready   = 1'b0;
    data_in = 8'h77;
    req_tgl = ~req_tgl;
    wait_valid("viol_first", ok);
    data_in = 8'h11;
    req_tgl = ~req_tgl;
    m_overrun = 1'b1;
    repeat (4) @(negedge clock);
    n_tests++;
    if (overrun !== 1'b1 || data_out !== 8'h77 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL viol_flag: ovr=%b data=%h valid=%b required 1 77 1",
               overrun, data_out, valid);
    end
    ready = 1'b1;
    @(negedge clock);
    m_count++;
    m_ack = ~m_ack;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (valid === 1'b1 && data_out === 8'h11) ok = 1'b1;
      if (ok) break;
      @(negedge clock);
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL viol_second: data=%h valid=%b required 11 1", data_out, valid);
    end
    @(negedge clock);
    ready = 1'b0;
    m_count++;
    m_ack = ~m_ack;
    n_tests++;
    if (overrun !== 1'b1 || event_count !== exp_cnt() || ack_tgl !== m_ack || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL viol_done: ovr=%b cnt=%h ack=%b valid=%b required 1 %h %b 0",
               overrun, event_count, ack_tgl, valid, exp_cnt(), m_ack);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      xfer(8'($urandom), int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    for (int t = 0; t < 16; t++) begin
      xfer(8'($urandom), int'($urandom_range(0, 2)), "wrap");
    end
    n_tests++;
`ifdef TOGGLE_RX_COUNT_SAT_EN
    if (event_count !== 4'hF || ack_tgl !== 1'b0) begin
      n_fail++;
      $display("FAIL counter_boundary: cnt=%h ack=%b required f 0", event_count, ack_tgl);
    end
`else
    if (event_count !== 4'h0 || ack_tgl !== 1'b0) begin
      n_fail++;
      $display("FAIL counter_boundary: cnt=%h ack=%b required 0 0", event_count, ack_tgl);
    end
`endif
    xfer(8'h42, 1, "past_boundary");
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_violation();
    test_random();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
